ald_cycle_sequencer: RTL and testbench
======================================

// Module: ald_cycle_sequencer
// PURPOSE
//  Sequences the ALD reactor valve train through pumpdown, then N cycles of
//  precursor pulse -> purge -> water pulse -> purge, and stops when N cycles complete.
//  Sits between the 1 kHz tick generator and the valve output LEDs/drivers.
//  Replaces the per-rung timer chain with one state machine and one shared phase timer.
// PARAMETERS
//  TW            32     width of phase presets and phase timer (ticks)
//  CW            16     width of cycle preset/counter
//  PUMP_TIMEOUT  30000  max ticks in PUMPDOWN before FAULT (only with macro)
// PORTS
//  clk            in   1   system clock (CLOCK_50 domain)
//  rst            in   1   synchronous, active-high reset
//  tick           in   1   1-clk enable pulse, 1 kHz; all phase timing counts ticks
//  start          in   1   level; rising edge in IDLE starts a run
//  stop           in   1   level; graceful stop request (finish current cycle)
//  abort          in   1   level; immediate stop, all valves closed
//  pressure_ok    in   1   vacuum reached; gates PUMPDOWN -> PULSE1
//  t_pulse1       in   TW  precursor pulse length, ticks
//  t_purge1       in   TW  purge after precursor, ticks
//  t_pulse2       in   TW  water pulse length, ticks
//  t_purge2       in   TW  purge after water, ticks
//  n_cycles       in   CW  cycles per run
//  sv_prec        out  1   precursor valve (SV1)
//  sv_water       out  1   water valve (SV4)
//  vv1            out  1   vacuum valve 1
//  vv2            out  1   vacuum valve 2
//  busy           out  1   high in any state except IDLE/FAULT
//  done           out  1   1-clk pulse on run completion
//  fault          out  1   sticky; cleared only by rst
//  cycle_cnt      out  CW  completed cycles in current run
//  state_o        out  3   current state encoding
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timer 0, stop latch 0. All outputs registered.
//  - States: IDLE=0 PUMPDOWN=1 PULSE1=2 PURGE1=3 PULSE2=4 PURGE2=5 FAULT=7.
//  - Presets and n_cycles are sampled into shadow regs on start edge; later changes ignored.
//  - IDLE: start 0->1 with stop=0, abort=0 -> PUMPDOWN, cycle_cnt<=0. Start edge with
//    stop or abort high is ignored.
//  - PUMPDOWN: vv1=vv2=1. pressure_ok=1 -> PULSE1; if shadow n_cycles==0, -> IDLE
//    with done pulse instead.
//  - Phase timer: loaded with preset on phase entry. Decrements on tick. Phase exits on the
//    tick that takes it 1->0, so the phase lasts exactly preset ticks. Preset 0 -> phase
//    exits on the next clk without waiting for a tick.
//  - Valves: PULSE1 sv_prec=1. PURGE1 vv1=1. PULSE2 sv_water=1. PURGE2 vv2=1. All
//    others 0. sv_prec and sv_water are never high together, and never high in the
//    same clk as any vv.
//  - PURGE2 exit: cycle_cnt+1 (saturates at all-ones). If cycle_cnt+1==shadow n_cycles
//    or stop latch set -> IDLE with done=1 for 1 clk. Otherwise -> PULSE1.
//  - stop: latched while busy and cleared on IDLE entry. Run ends at the next PURGE2 exit;
//    the current cycle is always completed. stop in PUMPDOWN -> IDLE, no done.
//  - abort: from any busy state -> IDLE on the next clk. All valves 0 on that edge, no
//    done, cycle_cnt held. abort has priority over every other event.
//  - A tick arriving together with a phase entry does not count toward the new phase.
//  - rst mid-run: same as the reset state, with valves 0 on that edge.
//  - FAULT: all valves 0, busy=0, fault=1. Only rst leaves FAULT.
// CONFIGURATION
//  ALD_SEQ_PUMP_TIMEOUT_EN defined: PUMPDOWN counts ticks; at PUMP_TIMEOUT ticks without
//    pressure_ok -> FAULT, fault<=1.
//  Not defined: PUMPDOWN waits indefinitely. fault is tied 0 and FAULT is unreachable.
// TESTING
//  1 n_cycles=2, presets 3/4/3/4, pressure_ok=1 -> sv_prec 3 ticks, vv1 4, sv_water 3,
//    vv2 4, x2. done one clk after 28 ticks. cycle_cnt=2.
//  2 stop asserted during PULSE2 of cycle 1 (n_cycles=5) -> run finishes PURGE2, done=1,
//    cycle_cnt=1.
//  3 abort in PULSE1 -> next clk all valves 0, state IDLE, done never pulses.
//  4 t_purge1=0, n_cycles=1 -> PURGE1 lasts 1 clk. n_cycles=0 -> done right after pumpdown.
//  5 With macro, PUMP_TIMEOUT=10, pressure_ok=0 -> FAULT after 10 ticks. Without macro,
//    stays in PUMPDOWN.
//  6 Presets change mid-run -> phase lengths follow the start-time shadow values.

Source files
------------

// File: rtl/ald_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// ald_cycle_sequencer
//   Drives the ALD reactor valve train: pumpdown, then N cycles of
//   precursor pulse -> purge -> water pulse -> purge, then back to idle.
//   One state machine and one shared phase timer; phase lengths are counted
//   in 1 kHz ticks.
//
//   Optional feature (macro ALD_SEQ_PUMP_TIMEOUT_EN):
//     defined     - PUMPDOWN gives up after PUMP_TIMEOUT ticks without
//                   pressure_ok and parks in FAULT (sticky until rst).
//     not defined - PUMPDOWN waits indefinitely; fault is always 0.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   tick            1-clk enable pulse (1 kHz), phase time base
//   start           level; rising edge in IDLE begins a run
//   stop            level; finish current cycle then stop
//   abort           level; stop immediately, valves closed
//   pressure_ok     vacuum reached, releases PUMPDOWN
//   t_pulse1..2     precursor / water pulse lengths (ticks)
//   t_purge1..2     purge lengths after each pulse (ticks)
//   n_cycles        cycles per run
//   sv_prec         precursor valve (SV1)
//   sv_water        water valve (SV4)
//   vv1, vv2        vacuum valves
//   busy            run in progress (not IDLE, not FAULT)
//   done            1-clk pulse when a run completes
//   fault           sticky pumpdown-timeout flag
//   cycle_cnt       completed cycles in the current run
//   state_o         current state encoding
// ---------------------------------------------------------------------------
module ald_cycle_sequencer #(
  parameter int unsigned TW           = 32,
  parameter int unsigned CW           = 16,
  parameter int unsigned PUMP_TIMEOUT = 30000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          abort,
  input  logic          pressure_ok,
  input  logic [TW-1:0] t_pulse1,
  input  logic [TW-1:0] t_purge1,
  input  logic [TW-1:0] t_pulse2,
  input  logic [TW-1:0] t_purge2,
  input  logic [CW-1:0] n_cycles,
  output logic          sv_prec,
  output logic          sv_water,
  output logic          vv1,
  output logic          vv2,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [CW-1:0] cycle_cnt,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUMPDOWN = 3'd1,
    S_PULSE1   = 3'd2,
    S_PURGE1   = 3'd3,
    S_PULSE2   = 3'd4,
    S_PURGE2   = 3'd5,
    S_FAULT    = 3'd7
  } state_t;

  localparam logic [TW-1:0] PUMP_PRESET = TW'(PUMP_TIMEOUT);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          stop_q, stop_d;
  logic          start_prev_q;
  logic          load_sh;
  logic          done_d;

  // Run parameters captured at the start edge
  logic [TW-1:0] sh_p1_q, sh_u1_q, sh_p2_q, sh_u2_q;
  logic [CW-1:0] sh_n_q;

  // Registered outputs
  logic          sv_prec_q, sv_water_q, vv1_q, vv2_q, busy_q, done_q, fault_q;

  logic          start_edge;
  logic          in_run;
  logic          timer_exit;
  logic          stop_eff;

  assign start_edge = start & ~start_prev_q;
  assign in_run     = state_q inside {S_PUMPDOWN, S_PULSE1, S_PURGE1, S_PULSE2, S_PURGE2};
  // A zero preset exits on the next clk; otherwise the tick taking 1->0 exits.
  assign timer_exit = (timer_q == '0) || (tick && (timer_q == TW'(1)));
  assign stop_eff   = stop_q | stop;
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    load_sh = 1'b0;

    if (in_run && stop) begin
      stop_d = 1'b1;
    end

    if (in_run && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge && !stop && !abort) begin
            state_d = S_PUMPDOWN;
            cnt_d   = '0;
            load_sh = 1'b1;
            timer_d = PUMP_PRESET;
          end
        end
        S_PUMPDOWN: begin
          if (stop_eff) begin
            state_d = S_IDLE;
          end else if (pressure_ok) begin
            if (sh_n_q == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_PULSE1;
              timer_d = sh_p1_q;
            end
          end else begin
`ifdef ALD_SEQ_PUMP_TIMEOUT_EN
            // The phase timer doubles as the pumpdown watchdog
            if (timer_exit) begin
              state_d = S_FAULT;
            end else if (tick) begin
              timer_d = timer_q - 1'b1;
            end
`endif
          end
        end
        S_PULSE1: begin
          if (timer_exit) begin
            state_d = S_PURGE1;
            timer_d = sh_u1_q;
          end else if (tick) begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_PURGE1: begin
          if (timer_exit) begin
            state_d = S_PULSE2;
            timer_d = sh_p2_q;
          end else if (tick) begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_PULSE2: begin
          if (timer_exit) begin
            state_d = S_PURGE2;
            timer_d = sh_u2_q;
          end else if (tick) begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_PURGE2: begin
          if (timer_exit) begin
            cnt_d = cnt_inc;
            if ((cnt_inc == sh_n_q) || stop_eff) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_PULSE1;
              timer_d = sh_p1_q;
            end
          end else if (tick) begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (state_d == S_IDLE) begin
      stop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      cnt_q        <= '0;
      stop_q       <= 1'b0;
      start_prev_q <= 1'b0;
      sh_p1_q      <= '0;
      sh_u1_q      <= '0;
      sh_p2_q      <= '0;
      sh_u2_q      <= '0;
      sh_n_q       <= '0;
      sv_prec_q    <= 1'b0;
      sv_water_q   <= 1'b0;
      vv1_q        <= 1'b0;
      vv2_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      stop_q       <= stop_d;
      start_prev_q <= start;
      if (load_sh) begin
        sh_p1_q <= t_pulse1;
        sh_u1_q <= t_purge1;
        sh_p2_q <= t_pulse2;
        sh_u2_q <= t_purge2;
        sh_n_q  <= n_cycles;
      end
      // Outputs decode the next state so they change on the same edge as it
      sv_prec_q  <= (state_d == S_PULSE1);
      sv_water_q <= (state_d == S_PULSE2);
      vv1_q      <= (state_d == S_PUMPDOWN) || (state_d == S_PURGE1);
      vv2_q      <= (state_d == S_PUMPDOWN) || (state_d == S_PURGE2);
      busy_q     <= state_d inside {S_PUMPDOWN, S_PULSE1, S_PURGE1, S_PULSE2, S_PURGE2};
      done_q     <= done_d;
`ifdef ALD_SEQ_PUMP_TIMEOUT_EN
      fault_q    <= (state_d == S_FAULT);
`else
      fault_q    <= 1'b0;
`endif
    end
  end

  assign sv_prec   = sv_prec_q;
  assign sv_water  = sv_water_q;
  assign vv1       = vv1_q;
  assign vv2       = vv2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign cycle_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ald_cycle_sequencer.sv
module tb_ald_cycle_sequencer;
  localparam int TW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          abort = 1'b0;
  logic          pressure_ok = 1'b0;
  logic [TW-1:0] t_pulse1 = '0, t_purge1 = '0, t_pulse2 = '0, t_purge2 = '0;
  logic [CW-1:0] n_cycles = '0;
  logic          sv_prec, sv_water, vv1, vv2, busy, done, fault;
  logic [CW-1:0] cycle_cnt;
  logic [2:0]    state_o;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ald_cycle_sequencer #(.TW(TW), .CW(CW), .PUMP_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .abort(abort),
    .pressure_ok(pressure_ok), .t_pulse1(t_pulse1), .t_purge1(t_purge1),
    .t_pulse2(t_pulse2), .t_purge2(t_purge2), .n_cycles(n_cycles),
    .sv_prec(sv_prec), .sv_water(sv_water), .vv1(vv1), .vv2(vv2), .busy(busy),
    .done(done), .fault(fault), .cycle_cnt(cycle_cnt), .state_o(state_o)
  );

  // Reference model: a run is a list of (valve phase, length in ticks) segments
  typedef struct {int ph; int ticks; int clks; bit last_tick;} seg_t;
  seg_t obs_q[$];
  int   exp_ph[$];
  int   exp_len[$];
  int   cur_ph = 0, cur_ticks = 0, cur_clks = 0;
  bit   cur_last = 1'b0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // 0 none, 1 precursor, 2 purge1, 3 water, 4 purge2, 5 pumpdown, 6 illegal
  function automatic int phase_now();
    if (vv1 && vv2 && !sv_prec && !sv_water) return 5;
    if (sv_prec && !sv_water && !vv1 && !vv2) return 1;
    if (vv1 && !vv2 && !sv_prec && !sv_water) return 2;
    if (sv_water && !sv_prec && !vv1 && !vv2) return 3;
    if (vv2 && !vv1 && !sv_prec && !sv_water) return 4;
    if (!vv1 && !vv2 && !sv_prec && !sv_water) return 0;
    return 6;
  endfunction

  // Advance one clock; the tick drawn here is sampled by the DUT while the
  // currently visible phase is active, so it is credited to that phase.
  task automatic step();
    int ph;
    @(negedge clk);
    tick = ($urandom_range(0, 2) == 0);
    ph = phase_now();
    if (ph != cur_ph) begin
      if (cur_ph >= 1 && cur_ph <= 4)
        obs_q.push_back('{cur_ph, cur_ticks, cur_clks, cur_last});
      cur_ph = ph;
      cur_ticks = 0;
      cur_clks = 0;
    end
    cur_clks++;
    if (tick) cur_ticks++;
    cur_last = tick;
    if (done) done_cnt++;
    chk("valve_excl", {sv_prec & sv_water, (sv_prec | sv_water) & (vv1 | vv2)}, 2'b00);
  endtask

  task automatic build_exp(input int n, input int p1, input int u1, input int p2, input int u2);
    exp_ph.delete();
    exp_len.delete();
    for (int c = 0; c < n; c++) begin
      exp_ph.push_back(1); exp_len.push_back(p1);
      exp_ph.push_back(2); exp_len.push_back(u1);
      exp_ph.push_back(3); exp_len.push_back(p2);
      exp_ph.push_back(4); exp_len.push_back(u2);
    end
  endtask

  task automatic check_segs(input string tag);
    chk({tag, "_seg_count"}, obs_q.size(), exp_ph.size());
    for (int i = 0; i < exp_ph.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_seg%0d_phase", tag, i), obs_q[i].ph, exp_ph[i]);
      if (exp_len[i] == 0)
        chk($sformatf("%s_seg%0d_clks", tag, i), obs_q[i].clks, 1);
      else
        chk($sformatf("%s_seg%0d_ticks", tag, i), {obs_q[i].ticks, obs_q[i].last_tick},
            {exp_len[i], 1'b1});
    end
  endtask

  task automatic set_presets(input int n, input int p1, input int u1, input int p2, input int u2);
    n_cycles = CW'(n);
    t_pulse1 = TW'(p1);
    t_purge1 = TW'(u1);
    t_pulse2 = TW'(p2);
    t_purge2 = TW'(u2);
    build_exp(n, p1, u1, p2, u2);
    obs_q.delete();
    done_cnt = 0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) break;
    end
  endtask

  task automatic wait_phase(input int ph, input int min_segs, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (phase_now() == ph && obs_q.size() >= min_segs) break;
    end
    chk($sformatf("reached_phase%0d", ph), phase_now(), ph);
  endtask

  task automatic finish_checks(input string tag, input int exp_cnt);
    chk({tag, "_done_seen"}, done_cnt, 1);
    check_segs(tag);
    chk({tag, "_cycle_cnt"}, cycle_cnt, exp_cnt);
    chk({tag, "_state_idle"}, {state_o, busy}, 4'b0000);
    step();
    chk({tag, "_done_1clk"}, {done, done_cnt}, {1'b0, 32'd1});
  endtask

  task automatic do_run(input string tag, input int n, input int p1, input int u1,
                        input int p2, input int u2, input bit scramble);
    pressure_ok = 1'b1;
    set_presets(n, p1, u1, p2, u2);
    begin_run();
    if (scramble) begin
      t_pulse1 = TW'($urandom_range(0, 9));
      t_purge1 = TW'($urandom_range(0, 9));
      t_pulse2 = TW'($urandom_range(0, 9));
      t_purge2 = TW'($urandom_range(0, 9));
      n_cycles = CW'($urandom_range(0, 6));
    end
    wait_done(8000);
    finish_checks(tag, n);
  endtask

  initial begin
    int pt;

    // Reset
    rst = 1'b1;
    repeat (3) step();
    chk("reset_outputs", {sv_prec, sv_water, vv1, vv2, busy, done, fault}, 7'b0);
    chk("reset_state_cnt", {state_o, cycle_cnt}, 19'b0);
    rst = 1'b0;
    step();

    // Two full cycles with 3/4/3/4
    do_run("basic", 2, 3, 4, 3, 4, 1'b0);

    // Random presets, inputs scrambled after start
    for (int r = 0; r < 4; r++)
      do_run($sformatf("rand%0d", r), $urandom_range(1, 3), $urandom_range(0, 5),
             $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1'b1);

    // Zero-length purge and zero cycles
    do_run("zero_purge", 1, 2, 0, 2, 3, 1'b0);
    do_run("zero_cycles", 0, 3, 3, 3, 3, 1'b0);

    // Graceful stop during the first water pulse
    pressure_ok = 1'b1;
    set_presets(5, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                $urandom_range(1, 4));
    build_exp(1, int'(t_pulse1), int'(t_purge1), int'(t_pulse2), int'(t_purge2));
    begin_run();
    wait_phase(3, 2, 2000);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(4000);
    finish_checks("stop", 1);

    // Abort in the second precursor pulse
    set_presets(3, 30, 1, 1, 1);
    begin_run();
    wait_phase(1, 4, 2000);
    abort = 1'b1;
    step();
    chk("abort_outputs", {sv_prec, sv_water, vv1, vv2, busy, done}, 6'b0);
    chk("abort_state", state_o, 0);
    chk("abort_cnt_held", cycle_cnt, 1);
    abort = 1'b0;
    repeat (40) step();
    chk("abort_no_done", {done_cnt, state_o}, {32'd0, 3'd0});

    // Start edge ignored while stop or abort is high
    stop = 1'b1;
    start = 1'b1;
    repeat (3) step();
    chk("start_with_stop", {state_o, busy}, 4'b0);
    start = 1'b0;
    stop = 1'b0;
    step();
    abort = 1'b1;
    start = 1'b1;
    repeat (3) step();
    chk("start_with_abort", {state_o, busy}, 4'b0);
    start = 1'b0;
    abort = 1'b0;
    step();

    // Stop while waiting for vacuum
    pressure_ok = 1'b0;
    set_presets(2, 2, 2, 2, 2);
    begin_run();
    repeat (5) step();
    chk("pump_waiting", {state_o, vv1, vv2, busy}, {3'd1, 3'b111});
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pump_stop_idle", {state_o, busy, vv1, vv2}, 6'b0);
    repeat (5) step();
    chk("pump_stop_no_done", done_cnt, 0);

    // Reset mid-run
    pressure_ok = 1'b1;
    set_presets(2, 2, 2, 2, 2);
    begin_run();
    wait_phase(3, 2, 2000);
    rst = 1'b1;
    step();
    chk("midrun_rst_outputs", {sv_prec, sv_water, vv1, vv2, busy, done, fault}, 7'b0);
    chk("midrun_rst_state", {state_o, cycle_cnt}, 19'b0);
    rst = 1'b0;
    step();

    // Pumpdown with no vacuum
    pressure_ok = 1'b0;
    set_presets(2, 2, 2, 2, 2);
    begin_run();
    pt = 0;
`ifdef ALD_SEQ_PUMP_TIMEOUT_EN
    for (int i = 0; i < 1000; i++) begin
      step();
      if (state_o != 3'd1) break;
      if (tick) pt++;
    end
    chk("timeout_ticks", pt, 10);
    chk("timeout_fault", {state_o, fault, busy, sv_prec, sv_water, vv1, vv2}, {3'd7, 6'b100000});
    repeat (5) step();
    chk("fault_sticky", {state_o, fault}, {3'd7, 1'b1});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("fault_cleared", {state_o, fault}, 4'b0);
`else
    for (int i = 0; i < 1000 && pt < 40; i++) begin
      step();
      if (state_o == 3'd1 && tick) pt++;
    end
    chk("pump_wait_ticks", pt, 40);
    step();
    chk("pump_no_timeout", {state_o, fault, busy, vv1, vv2}, {3'd1, 4'b0111});
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pump_long_stop", {state_o, fault, done_cnt}, {3'd0, 1'b0, 32'd0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
